// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Two-requester round-robin arbiter for a shared memory address
//            port, sequencing one access at a time with ready and timeout.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_a,
  input  logic [WIDTH-1:0] addr_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] addr_b,
  input  logic             mem_ready,
  output logic             mem_valid,
  output logic [WIDTH-1:0] mem_addr,
  output logic             sel,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             done_a,
  output logic             done_b,
  output logic             err
);

  localparam int                CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_BUSY_A = 2'd1;
  localparam logic [1:0] S_BUSY_B = 2'd2;

  localparam logic LAST_A = 1'b0;
  localparam logic LAST_B = 1'b1;

  logic [1:0]       state_q, state_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] addr_q, addr_d;

  logic             mem_valid_q, mem_valid_d;
  logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic             sel_q, sel_d;
  logic             gnt_a_q, gnt_a_d;
  logic             gnt_b_q, gnt_b_d;
  logic             done_a_q, done_a_d;
  logic             done_b_q, done_b_d;
  logic             err_q, err_d;

  logic             cand_a, cand_b;

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    done_a_d = 1'b0;
    done_b_d = 1'b0;
    err_d    = 1'b0;

    // A request whose previous access just ended is held over; ignore it once.
    cand_a = req_a & ~(done_a_q | err_q);
    cand_b = req_b & ~(done_b_q | err_q);

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (cand_a && (!cand_b || last_q == LAST_B)) begin
          state_d = S_BUSY_A;
          addr_d  = addr_a;
        end else if (cand_b) begin
          state_d = S_BUSY_B;
          addr_d  = addr_b;
        end
      end
      S_BUSY_A, S_BUSY_B: begin
        if (mem_ready) begin
          state_d  = S_IDLE;
          cnt_d    = '0;
          last_d   = (state_q == S_BUSY_B) ? LAST_B : LAST_A;
          done_a_d = (state_q == S_BUSY_A);
          done_b_d = (state_q == S_BUSY_B);
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          last_d  = (state_q == S_BUSY_B) ? LAST_B : LAST_A;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are registered images of the next state.
    mem_valid_d = (state_d != S_IDLE);
    gnt_a_d     = (state_d == S_BUSY_A);
    gnt_b_d     = (state_d == S_BUSY_B);
    sel_d       = (state_d == S_BUSY_B);
    mem_addr_d  = mem_valid_d ? addr_d : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      last_q      <= LAST_B;
      cnt_q       <= '0;
      addr_q      <= '0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      sel_q       <= 1'b0;
      gnt_a_q     <= 1'b0;
      gnt_b_q     <= 1'b0;
      done_a_q    <= 1'b0;
      done_b_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      sel_q       <= sel_d;
      gnt_a_q     <= gnt_a_d;
      gnt_b_q     <= gnt_b_d;
      done_a_q    <= done_a_d;
      done_b_q    <= done_b_d;
      err_q       <= err_d;
    end
  end

  assign mem_valid = mem_valid_q;
  assign mem_addr  = mem_addr_q;
  assign sel       = sel_q;
  assign gnt_a     = gnt_a_q;
  assign gnt_b     = gnt_b_q;
  assign done_a    = done_a_q;
  assign done_b    = done_b_q;
  assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed and randomized checking of mem_port_arbiter against a
//            transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int WIDTH   = 16;
  localparam int TIMEOUT = 15;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             req_a = 1'b0;
  logic [WIDTH-1:0] addr_a = '0;
  logic             req_b = 1'b0;
  logic [WIDTH-1:0] addr_b = '0;
  logic             mem_ready = 1'b0;
  logic             mem_valid;
  logic [WIDTH-1:0] mem_addr;
  logic             sel, gnt_a, gnt_b, done_a, done_b, err;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .addr_a(addr_a),
    .req_b(req_b), .addr_b(addr_b),
    .mem_ready(mem_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .sel(sel),
    .gnt_a(gnt_a), .gnt_b(gnt_b),
    .done_a(done_a), .done_b(done_b), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the port, for how many cycles, and the
  // pulses raised when an access ends. 0 = nobody, 1 = A, 2 = B.
  int               m_owner, m_elapsed, m_last, m_win;
  logic [WIDTH-1:0] m_addr;
  logic             e_done_a, e_done_b, e_err;
  logic             n_done_a, n_done_b, n_err, want_a, want_b;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_owner = 0; m_elapsed = 0; m_last = 2; m_addr = '0;
      e_done_a = 1'b0; e_done_b = 1'b0; e_err = 1'b0;
    end else begin
      n_done_a = 1'b0; n_done_b = 1'b0; n_err = 1'b0;
      if (m_owner == 0) begin
        want_a = req_a && !e_done_a && !e_err;
        want_b = req_b && !e_done_b && !e_err;
        if (want_a && want_b) m_win = (m_last == 1) ? 2 : 1;
        else if (want_a)      m_win = 1;
        else if (want_b)      m_win = 2;
        else                  m_win = 0;
        if (m_win != 0) begin
          m_owner   = m_win;
          m_addr    = (m_win == 1) ? addr_a : addr_b;
          m_elapsed = 1;
        end
      end else if (mem_ready) begin
        n_done_a = (m_owner == 1);
        n_done_b = (m_owner == 2);
        m_last   = m_owner;
        m_owner  = 0;
      end else if (m_elapsed == TIMEOUT) begin
        n_err   = 1'b1;
        m_last  = m_owner;
        m_owner = 0;
      end else begin
        m_elapsed++;
      end
      e_done_a = n_done_a; e_done_b = n_done_b; e_err = n_err;
    end
  end

  always @(negedge clk) begin
    check("outputs",
          {9'd0, mem_valid, gnt_a, gnt_b, sel, done_a, done_b, err, mem_addr},
          {9'd0, (m_owner != 0), (m_owner == 1), (m_owner == 2), (m_owner == 2),
           e_done_a, e_done_b, e_err, (m_owner != 0) ? m_addr : 16'h0000});
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int divs [6] = '{1, 2, 3, 8, 40, 60};
  int div;

  initial begin
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    check("reset_valid", mem_valid, 0);
    check("reset_addr", mem_addr, 0);
    check("reset_gnt", {gnt_a, gnt_b, sel}, 0);

    // Single A access with an address change mid-access.
    req_a = 1'b1; addr_a = 16'd10;
    step();
    check("t1_busy", {mem_valid, gnt_a, gnt_b, sel}, 4'b1100);
    check("t1_addr", mem_addr, 10);
    addr_a = 16'd13;
    step();
    check("t4_addr_hold", mem_addr, 10);
    check("t1_sel", sel, 0);
    mem_ready = 1'b1;
    step();
    check("t1_done", {done_a, done_b, err, mem_valid}, 4'b1000);
    check("t1_idle_addr", mem_addr, 0);
    req_a = 1'b0; mem_ready = 1'b0;
    step();
    check("t1_pulse_end", done_a, 0);

    // Timeout on B.
    req_b = 1'b1; addr_b = 16'h00FF;
    step();
    for (int i = 0; i < TIMEOUT; i++) begin
      check("t3_busy", {mem_valid, gnt_b, sel}, 3'b111);
      check("t3_addr", mem_addr, 16'h00FF);
      step();
    end
    check("t3_err", {err, done_b, mem_valid}, 3'b100);
    req_b = 1'b0;
    step();
    check("t3_err_end", err, 0);

    // Contention: strict alternation starting with A.
    req_a = 1'b1; req_b = 1'b1; addr_a = 16'd13; addr_b = 16'd12; mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("t2_gnt", {gnt_a, gnt_b, sel}, (k % 2 == 0) ? 3'b100 : 3'b011);
      check("t2_addr", mem_addr, (k % 2 == 0) ? 13 : 12);
      step();
      check("t2_done", {done_a, done_b, err}, (k % 2 == 0) ? 3'b100 : 3'b010);
    end
    req_a = 1'b0; req_b = 1'b0; mem_ready = 1'b0;
    step();

    // Asynchronous reset in the middle of a B access.
    req_b = 1'b1; addr_b = 16'h0055;
    step();
    check("t5_busy_b", gnt_b, 1);
    #4 reset = 1'b1;
    #1;
    check("t5_async", {mem_valid, gnt_a, gnt_b, sel, done_a, done_b, err}, 0);
    check("t5_async_addr", mem_addr, 0);
    req_a = 1'b1; addr_a = 16'h0A0A; addr_b = 16'h0B0B;
    @(posedge clk);
    #2 reset = 1'b0;
    step();
    check("t5_first_a", {gnt_a, gnt_b}, 2'b10);
    check("t5_addr", mem_addr, 16'h0A0A);

    // Ready on the final allowed cycle completes; held request is not regranted.
    for (int i = 1; i < TIMEOUT; i++) step();
    check("t6_last_busy", mem_valid, 1);
    mem_ready = 1'b1; req_b = 1'b0;
    step();
    check("t6_done", {done_a, err}, 2'b10);
    mem_ready = 1'b0;
    step();
    check("t6_no_regrant", {mem_valid, gnt_a}, 2'b00);
    step();
    check("t6_regrant", gnt_a, 1);
    mem_ready = 1'b1; req_a = 1'b0;
    step();
    check("t6_done2", done_a, 1);
    mem_ready = 1'b0;
    step();

    // Randomized traffic with varying memory responsiveness.
    for (int i = 0; i < 3000; i++) begin
      div = divs[i / 500];
      req_a     = ($urandom % 4) != 0;
      req_b     = ($urandom % 4) != 0;
      addr_a    = WIDTH'($urandom);
      addr_b    = WIDTH'($urandom);
      mem_ready = ($urandom % div) == 0;
      if ($urandom % 400 == 0) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
